// File: rtl/bf_pair_serializer_256.sv
// Output-side reorder for a radix-2 SDF FFT stage: forwards y1 immediately and
// buffers y2 for a frame, then drains the buffered y2 words in arrival order.
module bf_pair_serializer_256 #(
    parameter int float_len = 32,
    parameter int depth     = 256,
    parameter int addr_len  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*float_len-1:0] data_in1,
    input  logic [2*float_len-1:0] data_in2,
    input  logic                   data_in_valid,
    output logic                   ready,
    output logic [2*float_len-1:0] data_out,
    output logic                   data_out_valid,
    output logic                   data_out_first,
    output logic                   overrun
);

    typedef enum logic {
        COLLECT,
        DRAIN
    } state_t;

    localparam logic [addr_len-1:0] LAST = addr_len'(depth - 1);

    state_t              state;
    logic [addr_len-1:0] pair_cnt;
    logic [addr_len-1:0] rd_cnt;
    logic                accept;

    logic [2*float_len-1:0] mem [depth];

    assign ready  = (state == COLLECT);
    assign accept = data_in_valid && ready;

    // Storage has no reset; stale words are always overwritten before a drain reads them.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[pair_cnt] <= data_in2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= COLLECT;
            pair_cnt       <= '0;
            rd_cnt         <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_out_first <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            data_out_first <= 1'b0;
            if (state == COLLECT) begin
                if (data_in_valid) begin
                    data_out       <= data_in1;
                    data_out_valid <= 1'b1;
                    data_out_first <= (pair_cnt == '0);
                    pair_cnt       <= pair_cnt + addr_len'(1);
                    if (pair_cnt == LAST) begin
                        state  <= DRAIN;
                        rd_cnt <= '0;
                    end
                end
            end else begin
                // Drain is unstallable; the registered read is the output register.
                data_out       <= mem[rd_cnt];
                data_out_valid <= 1'b1;
                rd_cnt         <= rd_cnt + addr_len'(1);
                if (rd_cnt == LAST) begin
                    state <= COLLECT;
                end
                if (data_in_valid) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bf_pair_serializer_256.sv
// Scoreboard bench for bf_pair_serializer_256 at depth 256 and a depth-4 instance.
module tb_bf_pair_serializer_256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic [63:0] a_in1 = '0, a_in2 = '0, b_in1 = '0, b_in2 = '0;
    logic        a_vld = 1'b0, b_vld = 1'b0;
    logic [63:0] a_dout, b_dout;
    logic        a_rdy, a_ov, a_ovr, a_fst, b_rdy, b_ov, b_ovr, b_fst;

    bf_pair_serializer_256 dut_a (
        .clk(clk), .rst(rst_a), .data_in1(a_in1), .data_in2(a_in2),
        .data_in_valid(a_vld), .ready(a_rdy), .data_out(a_dout),
        .data_out_valid(a_ov), .data_out_first(a_fst), .overrun(a_ovr)
    );

    bf_pair_serializer_256 #(.float_len(32), .depth(4), .addr_len(2)) dut_b (
        .clk(clk), .rst(rst_b), .data_in1(b_in1), .data_in2(b_in2),
        .data_in_valid(b_vld), .ready(b_rdy), .data_out(b_dout),
        .data_out_valid(b_ov), .data_out_first(b_fst), .overrun(b_ovr)
    );

    typedef struct {
        logic [63:0] data;
        logic        first;
        int unsigned due;
    } exp_t;

    exp_t        q0[$], q1[$];
    logic [63:0] p0[$], p1[$];
    int unsigned total = 0, bad = 0, ec = 0;
    bit          m_drain[2], m_ov[2];
    int unsigned m_cnt[2];
    logic [63:0] last_out[2];
    bit          seen_dead = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_exp(int id, exp_t e);
        if (id == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    // Reference model, evaluated on every rising edge with the sampled inputs.
    task automatic model_step(input int id, input int unsigned d, input logic r,
                              input logic v, input logic [63:0] x1, input logic [63:0] x2);
        logic [63:0] y;
        if (r) begin
            m_drain[id] = 1'b0; m_cnt[id] = 0; m_ov[id] = 1'b0; last_out[id] = '0;
            if (id == 0) begin q0.delete(); p0.delete(); end
            else begin q1.delete(); p1.delete(); end
        end else if (!m_drain[id]) begin
            if (v) begin
                push_exp(id, '{x1, (m_cnt[id] == 0), ec});
                if (id == 0) p0.push_back(x2); else p1.push_back(x2);
                m_cnt[id]++;
                if (m_cnt[id] == d) begin
                    m_drain[id] = 1'b1;
                    m_cnt[id]   = 0;
                    for (int unsigned k = 0; k < d; k++) begin
                        y = (id == 0) ? p0.pop_front() : p1.pop_front();
                        push_exp(id, '{y, 1'b0, ec + 1 + k});
                    end
                end
            end
        end else begin
            if (v) m_ov[id] = 1'b1;
            m_cnt[id]++;
            if (m_cnt[id] == d) begin
                m_drain[id] = 1'b0;
                m_cnt[id]   = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        ec++;
        model_step(0, 256, rst_a, a_vld, a_in1, a_in2);
        model_step(1, 4, rst_b, b_vld, b_in1, b_in2);
    end

    task automatic mon(input int id, input logic [63:0] dout, input logic vld,
                       input logic fst, input logic rdy, input logic ov);
        exp_t        e;
        string       p;
        int unsigned n;
        p = (id == 0) ? "a." : "b.";
        n = (id == 0) ? q0.size() : q1.size();
        chk({p, "ready"}, rdy, !m_drain[id]);
        chk({p, "overrun"}, ov, m_ov[id]);
        if (vld && dout == 64'hDEAD) seen_dead = 1'b1;
        if (vld) begin
            if (n == 0) begin
                chk({p, "unexpected_valid"}, vld, 1'b0);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk({p, "data"}, dout, e.data);
                chk({p, "first"}, fst, e.first);
                chk({p, "timing"}, ec, e.due);
                last_out[id] = e.data;
            end
        end else begin
            chk({p, "first_idle"}, fst, 1'b0);
            chk({p, "hold"}, dout, last_out[id]);
            if (n > 0) begin
                e = (id == 0) ? q0[0] : q1[0];
                if (e.due <= ec) begin
                    chk({p, "missing_out"}, e.data + 64'd1, e.data);
                    if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (ec > 0) begin
            mon(0, a_dout, a_ov, a_fst, a_rdy, a_ovr);
            mon(1, b_dout, b_ov, b_fst, b_rdy, b_ovr);
        end
    end

    task automatic drive(input int id, input logic v, input logic [63:0] x1, input logic [63:0] x2);
        if (id == 0) begin a_vld = v; a_in1 = x1; a_in2 = x2; end
        else begin b_vld = v; b_in1 = x1; b_in2 = x2; end
    endtask

    // Presents one pair on the first cycle ready is high (bounded wait).
    task automatic send(input int id, input logic [63:0] x1, input logic [63:0] x2);
        int n = 0;
        @(negedge clk);
        while (((id == 0) ? a_rdy : b_rdy) !== 1'b1 && n < 1000) begin
            drive(id, 1'b0, '0, '0);
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("ready_timeout", 64'd0, 64'd1);
        drive(id, 1'b1, x1, x2);
    endtask

    task automatic idle(input int id, input int n);
        repeat (n) begin
            @(negedge clk);
            drive(id, 1'b0, '0, '0);
        end
    endtask

    task automatic send_frame(input int id, input int unsigned d, input logic [63:0] base);
        for (int unsigned k = 0; k < d; k++) send(id, base + k, base + d + k);
    endtask

    task automatic chk_reset_a();
        chk("rst.data_out", a_dout, 64'd0);
        chk("rst.valid", a_ov, 1'b0);
        chk("rst.first", a_fst, 1'b0);
        chk("rst.overrun", a_ovr, 1'b0);
        chk("rst.ready", a_rdy, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_a();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // contiguous frame
        send_frame(0, 256, 0);
        idle(0, 260);

        // gapped frame: valid every third cycle
        for (int unsigned k = 0; k < 256; k++) begin
            send(0, 64'(k), 64'(256 + k));
            idle(0, 2);
        end
        idle(0, 260);

        // overrun: pairs arriving during drain are dropped
        send_frame(0, 256, 0);
        repeat (3) begin
            @(negedge clk);
            drive(0, 1'b1, 64'hDEAD, 64'hDEAD);
        end
        idle(0, 260);
        chk("overrun_set", a_ovr, 1'b1);

        // back-to-back frames
        send_frame(0, 256, 0);
        send_frame(0, 256, 1000);
        idle(0, 260);
        chk("overrun_sticky", a_ovr, 1'b1);

        // reset mid-frame then a clean frame
        for (int unsigned k = 0; k < 100; k++) send(0, 64'(k), 64'(256 + k));
        @(negedge clk);
        drive(0, 1'b0, '0, '0);
        rst_a = 1'b1;
        @(negedge clk);
        chk_reset_a();
        rst_a = 1'b0;
        send_frame(0, 256, 0);
        idle(0, 260);
        chk("overrun_cleared", a_ovr, 1'b0);

        // small depth: three back-to-back frames
        for (int unsigned f = 0; f < 3; f++) send_frame(1, 4, 64'(f * 100));
        idle(1, 12);

        chk("a.queue_empty", 64'(q0.size()), 64'd0);
        chk("b.queue_empty", 64'(q1.size()), 64'd0);
        chk("no_dead_out", seen_dead, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
